pwr_iso_seq: RTL and testbench
==============================

PWR_ISO_SEQ -- requirements
Module: pwr_iso_seq

Interface
REQ-001 Parameter WIDTH, default 8: number of isolated signal channels crossing the switchable domain boundary.
REQ-002 Parameter CLAMP_MASK, default {WIDTH{1'b0}}: per-channel clamp value; bit=1 clamps high (OR-type cell), bit=0 clamps low (AND-type cell).
REQ-003 Parameter ISO_DLY, default 4, legal range >=1: cycles that isolation is held before power is removed, and before a wake completes.
REQ-004 Parameter PWR_DLY, default 8, legal range >=1: cycles allowed for supply ramp after power is restored.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 pd_req  input  1  level power-down request; 1 requests domain off, 0 requests domain on.
REQ-008 din  input  WIDTH  signals driven from the switchable domain.
REQ-009 dout  output  WIDTH  isolated signals to the always-on domain.
REQ-010 iso_en  output  1  registered isolation enable, 1 = clamps active.
REQ-011 pwr_en  output  1  registered power-switch enable, 1 = domain powered.
REQ-012 pd_ack  output  1  registered acknowledge; 1 = domain off or still waking.

Function
REQ-013 dout[i] SHALL equal CLAMP_MASK[i] when iso_en=1 and din[i] when iso_en=0, combinationally, with no added latency.
REQ-014 The FSM SHALL have states RUN, ISO_ON, PWR_OFF and PWR_UP, with all outputs decoded from the state register.
REQ-015 RUN: iso_en=0, pwr_en=1, pd_ack=0; pd_req=1 sampled -> ISO_ON with the counter loaded to ISO_DLY-1.
REQ-016 ISO_ON: iso_en=1, pwr_en=1, pd_ack=0; at counter=0 -> PWR_OFF, otherwise decrement.
REQ-017 In ISO_ON, pd_req=0 sampled SHALL abort to RUN on the next edge; power is never removed.
REQ-018 PWR_OFF: iso_en=1, pwr_en=0, pd_ack=1; remains there while pd_req=1; pd_req=0 -> PWR_UP with the counter loaded to PWR_DLY+ISO_DLY-1.
REQ-019 PWR_UP: iso_en=1, pwr_en=1, pd_ack=1; at counter=0 -> RUN; pd_req is ignored until the counter reaches 0.
REQ-020 If pd_req=1 on arrival in RUN from PWR_UP, RUN SHALL last exactly one cycle before re-entering ISO_ON.
REQ-021 Timing: pd_req sampled high at edge k -> iso_en=1 after edge k, pwr_en=0 and pd_ack=1 after edge k+ISO_DLY.
REQ-022 iso_en SHALL never be 0 while pwr_en is 0, in any state or transition.
REQ-023 The counter width SHALL be $clog2(PWR_DLY+ISO_DLY)+1 bits; the counter saturates at 0 and never wraps.

Reset
REQ-024 rst_n=0 sampled SHALL force state RUN, counter=0, iso_en=0, pwr_en=1 and pd_ack=0 on that edge, including mid-sequence.
REQ-025 Outputs SHALL take their reset values one edge after rst_n is sampled low; pd_req is not sampled during reset.

Configuration
REQ-026 With macro PWR_ISO_SEQ_RET_EN defined, output ports ret_save and ret_restore (1 bit each) SHALL be added, plus states SAVE and RESTORE.
REQ-027 With the macro, ISO_ON at counter=0 SHALL go to SAVE for one cycle (iso_en=1, pwr_en=1, ret_save=1), then to PWR_OFF.
REQ-028 With the macro, PWR_UP at counter=0 SHALL go to RESTORE for one cycle (iso_en=1, pwr_en=1, pd_ack=1, ret_restore=1), then to RUN.
REQ-029 With the macro, both ret_save and ret_restore SHALL be 0 in reset and in all other states.
REQ-030 Without the macro, the ports and states SHALL be absent and the sequence SHALL be as in REQ-015..REQ-019.

Verification
REQ-031 Defaults: pd_req 0->1 at edge 10 -> iso_en=1 after edge 10, pwr_en=0/pd_ack=1 after edge 14, dout=8'h00.
REQ-032 CLAMP_MASK=8'hA5, din=8'h3C: iso_en=1 -> dout=8'hA5; iso_en=0 -> dout=8'h3C.
REQ-033 pd_req pulsed high for 2 cycles -> ISO_ON abort, pwr_en stays 1, iso_en back to 0, pd_ack never 1.
REQ-034 From PWR_OFF, pd_req->0 -> pwr_en=1 next edge, iso_en/pd_ack drop after 12 further edges; with pd_req re-raised mid-wake -> 1 RUN cycle, then ISO_ON.
REQ-035 rst_n low during PWR_OFF -> pwr_en=1, iso_en=0, pd_ack=0 after that edge; assertion iso_en|pwr_en holds throughout.
REQ-036 With PWR_ISO_SEQ_RET_EN: ret_save is a 1-cycle pulse immediately before pwr_en falls; ret_restore is a 1-cycle pulse immediately before iso_en falls.

Source files
------------

// File: rtl/pwr_iso_seq.sv
// Power-domain isolation sequencer: clamps signals leaving a switchable
// domain, then removes power after an isolation hold time; on wake it
// restores power, waits for the supply ramp plus the isolation hold, and
// only then releases the clamps.
// Optional build macro PWR_ISO_SEQ_RET_EN adds SAVE/RESTORE states and the
// ret_save/ret_restore retention strobes.
module pwr_iso_seq #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] CLAMP_MASK = {WIDTH{1'b0}},
  parameter int              ISO_DLY    = 4,
  parameter int              PWR_DLY    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pd_req,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             iso_en,
  output logic             pwr_en,
  output logic             pd_ack
`ifdef PWR_ISO_SEQ_RET_EN
  ,
  output logic             ret_save,
  output logic             ret_restore
`endif
);

  // Counter must hold PWR_DLY+ISO_DLY-1; the extra bit keeps headroom.
  localparam int               CNT_W    = $clog2(PWR_DLY + ISO_DLY) + 1;
  localparam logic [CNT_W-1:0] ISO_LOAD = CNT_W'(ISO_DLY - 1);
  localparam logic [CNT_W-1:0] UP_LOAD  = CNT_W'(PWR_DLY + ISO_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef PWR_ISO_SEQ_RET_EN
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    ISO_ON  = 3'd1,
    PWR_OFF = 3'd2,
    PWR_UP  = 3'd3,
    SAVE    = 3'd4,
    RESTORE = 3'd5
  } state_e;
`else
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ISO_ON  = 2'd1,
    PWR_OFF = 2'd2,
    PWR_UP  = 2'd3
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and delay counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter only ever counts down to zero and holds.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (pd_req) begin
          state_d = ISO_ON;
          cnt_d   = ISO_LOAD;
        end
      end
      ISO_ON: begin
        if (!pd_req) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
`ifdef PWR_ISO_SEQ_RET_EN
          state_d = SAVE;
`else
          state_d = PWR_OFF;
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`ifdef PWR_ISO_SEQ_RET_EN
      SAVE: begin
        state_d = PWR_OFF;
      end
`endif
      PWR_OFF: begin
        if (!pd_req) begin
          state_d = PWR_UP;
          cnt_d   = UP_LOAD;
        end
      end
      PWR_UP: begin
        if (cnt_q == '0) begin
`ifdef PWR_ISO_SEQ_RET_EN
          state_d = RESTORE;
`else
          state_d = RUN;
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`ifdef PWR_ISO_SEQ_RET_EN
      RESTORE: begin
        state_d = RUN;
      end
`endif
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Control outputs decoded purely from the state register so they are
  // glitch-free, and isolation covers every state in which power is off.
  always_comb begin
    iso_en = (state_q != RUN);
    pwr_en = (state_q != PWR_OFF);
    pd_ack = (state_q == PWR_OFF) || (state_q == PWR_UP);
`ifdef PWR_ISO_SEQ_RET_EN
    pd_ack      = pd_ack || (state_q == RESTORE);
    ret_save    = (state_q == SAVE);
    ret_restore = (state_q == RESTORE);
`endif
  end

  // Clamp cells: each channel forced to its CLAMP_MASK bit while isolated.
  always_comb begin
    dout = iso_en ? CLAMP_MASK : din;
  end

endmodule

// File: tb/tb_pwr_iso_seq.sv
// Testbench for pwr_iso_seq: a hand-derived vector table for the directed
// sequences, followed by a random pd_req/reset run against a reference
// model; expected values go through a queue and are compared one step later.
module tb_pwr_iso_seq;

  localparam int         WIDTH = 8;
  localparam logic [7:0] MASK  = 8'hA5;
`ifdef PWR_ISO_SEQ_RET_EN
  localparam bit RET = 1'b1;
`else
  localparam bit RET = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pd_req = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       iso_en, pwr_en, pd_ack;
  logic       ret_save, ret_restore;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  typedef struct {
    logic       rstN;
    logic       pd;
    logic [7:0] d;
    logic       iso, pwr, ack, sv, rs;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] dout;
    logic       iso, pwr, ack, sv, rs;
  } exp_t;

  vec_t vecs[$];
  exp_t expQ[$];

  // Reference model: mode plus cycles elapsed in that mode.
  typedef enum int {M_RUN, M_ISO, M_SAVE, M_OFF, M_UP, M_RESTORE} mode_e;
  mode_e mMode = M_RUN;
  int    mEl   = 0;

  pwr_iso_seq #(
    .WIDTH(WIDTH), .CLAMP_MASK(MASK), .ISO_DLY(4), .PWR_DLY(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pd_req(pd_req), .din(din), .dout(dout),
    .iso_en(iso_en), .pwr_en(pwr_en), .pd_ack(pd_ack)
`ifdef PWR_ISO_SEQ_RET_EN
    , .ret_save(ret_save), .ret_restore(ret_restore)
`endif
  );

`ifndef PWR_ISO_SEQ_RET_EN
  assign ret_save    = 1'b0;
  assign ret_restore = 1'b0;
`endif

  always #5 clk = ~clk;

  // Safety invariant: clamps must be on whenever the domain is unpowered.
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (!(iso_en || pwr_en)) begin
        errors++;
        $display("[TB] FAIL iso_or_pwr at %0t: iso_en=%b pwr_en=%b required iso_en|pwr_en=1",
                 $time, iso_en, pwr_en);
      end
    end
  end

  task automatic cmpBit(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic cmpByte(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic addRows(input int n, input logic r, input logic p, input logic [7:0] d,
                         input logic iso, input logic pwr, input logic ack,
                         input logic sv, input logic rs);
    vec_t v;
    v.rstN = r; v.pd = p; v.d = d;
    v.iso = iso; v.pwr = pwr; v.ack = ack; v.sv = sv; v.rs = rs;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = expQ.pop_front();
      cmpBit("iso_en", e.idx, iso_en, e.iso);
      cmpBit("pwr_en", e.idx, pwr_en, e.pwr);
      cmpBit("pd_ack", e.idx, pd_ack, e.ack);
      cmpByte("dout", e.idx, dout, e.dout);
      if (RET) begin
        cmpBit("ret_save", e.idx, ret_save, e.sv);
        cmpBit("ret_restore", e.idx, ret_restore, e.rs);
      end
    end
  endtask

  // Drive one vector before a rising edge, queue its expectation, and
  // compare just after that edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    rst_n  = v.rstN;
    pd_req = v.pd;
    din    = v.d;
    e.idx = idx; e.iso = v.iso; e.pwr = v.pwr; e.ack = v.ack;
    e.sv = v.sv; e.rs = v.rs;
    e.dout = v.iso ? MASK : v.d;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    started = 1'b1;
    checkOutput();
  endtask

  task automatic modelStep(input logic r, input logic p);
    if (!r) begin
      mMode = M_RUN; mEl = 0;
    end else begin
      case (mMode)
        M_RUN:     if (p) begin mMode = M_ISO; mEl = 0; end
        M_ISO: begin
          if (!p) begin mMode = M_RUN; mEl = 0; end
          else if (mEl == 3) begin mMode = RET ? M_SAVE : M_OFF; mEl = 0; end
          else mEl++;
        end
        M_SAVE:    mMode = M_OFF;
        M_OFF:     if (!p) begin mMode = M_UP; mEl = 0; end
        M_UP: begin
          if (mEl == 11) begin mMode = RET ? M_RESTORE : M_RUN; mEl = 0; end
          else mEl++;
        end
        default:   mMode = M_RUN;
      endcase
    end
  endtask

  initial begin
    vec_t v;
    logic r, p;
    // Reset with pd_req high: must be ignored
    addRows(2, 0, 1, 8'h3C, 0, 1, 0, 0, 0);
    addRows(3, 1, 0, 8'h3C, 0, 1, 0, 0, 0);
    // Power-down: isolation at once, power off ISO_DLY edges later
    addRows(4, 1, 1, 8'h3C, 1, 1, 0, 0, 0);
    if (RET) addRows(1, 1, 1, 8'hC3, 1, 1, 0, 1, 0);
    addRows(3, 1, 1, 8'hC3, 1, 0, 1, 0, 0);
    // Wake: power back next edge, clamps released 12 edges later
    addRows(12, 1, 0, 8'h5A, 1, 1, 1, 0, 0);
    if (RET) addRows(1, 1, 0, 8'h5A, 1, 1, 1, 0, 1);
    addRows(2, 1, 0, 8'h3C, 0, 1, 0, 0, 0);
    // Two-cycle pulse: abort from ISO_ON, power never removed
    addRows(2, 1, 1, 8'h3C, 1, 1, 0, 0, 0);
    addRows(2, 1, 0, 8'h3C, 0, 1, 0, 0, 0);
    // Down again, then wake with pd_req re-raised during PWR_UP
    addRows(4, 1, 1, 8'hC3, 1, 1, 0, 0, 0);
    if (RET) addRows(1, 1, 1, 8'hC3, 1, 1, 0, 1, 0);
    addRows(1, 1, 1, 8'hC3, 1, 0, 1, 0, 0);
    addRows(1, 1, 0, 8'h3C, 1, 1, 1, 0, 0);
    addRows(11, 1, 1, 8'h3C, 1, 1, 1, 0, 0);
    if (RET) addRows(1, 1, 1, 8'h3C, 1, 1, 1, 0, 1);
    addRows(1, 1, 1, 8'h3C, 0, 1, 0, 0, 0);
    addRows(4, 1, 1, 8'h3C, 1, 1, 0, 0, 0);
    if (RET) addRows(1, 1, 1, 8'h3C, 1, 1, 0, 1, 0);
    addRows(1, 1, 1, 8'h3C, 1, 0, 1, 0, 0);
    // Reset while powered off
    addRows(1, 0, 1, 8'h3C, 0, 1, 0, 0, 0);
    addRows(2, 1, 0, 8'h96, 0, 1, 0, 0, 0);

    $display("[TB] applying %0d table vectors", vecs.size());
    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Random phase: DUT is in RUN with counter cleared after the table
    mMode = M_RUN; mEl = 0;
    p = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 6) == 0) p = ~p;
      r = ($urandom_range(0, 59) != 0);
      modelStep(r, p);
      v.rstN = r; v.pd = p; v.d = 8'($urandom);
      v.iso = (mMode != M_RUN);
      v.pwr = (mMode != M_OFF);
      v.ack = (mMode == M_OFF) || (mMode == M_UP) || (mMode == M_RESTORE);
      v.sv  = (mMode == M_SAVE);
      v.rs  = (mMode == M_RESTORE);
      applyStimulus(v, 1000 + i);
    end

    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d leftover expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
